// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus for the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bout;

    modport master (
        output start, A, B, Bin,
        input  busy, done, D, Bout
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, D, Bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: D = A - B - Bin, one bit per clock, LSB first.
// One full-subtractor cell plus operand/result shift registers.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_borrow;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_d;
    logic               r_bout;
    logic               r_busy;
    logic               r_done;

    logic               w_diff;
    logic               w_borrow_nxt;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_nxt;

    // Full-subtractor cell on the current LSBs
    assign w_diff       = r_a[0] ^ r_b[0] ^ r_borrow;
    assign w_borrow_nxt = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_borrow);
    assign w_last       = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_res_nxt    = {w_diff, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_d      <= '0;
            r_bout   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a      <= bus.A;
                        r_b      <= bus.B;
                        r_borrow <= bus.Bin;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_res    <= w_res_nxt;
                    r_borrow <= w_borrow_nxt;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    // Last bit: publish result together with the done pulse
                    if (w_last) begin
                        r_d     <= w_res_nxt;
                        r_bout  <= w_borrow_nxt;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.D    = r_d;
    assign bus.Bout = r_bout;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: randomized operands/start, arithmetic reference model.
module tb_serial_subtractor;
    localparam int unsigned W = 4;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        int           done_edge;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    int   n_tests = 0;
    int   n_fail  = 0;

    exp_t         q[$];
    int           next_free = 0;
    int           last_acc  = -1000;
    logic [W-1:0] last_d    = '0;
    logic         last_bout = 1'b0;

    serial_subtractor_if #(.WIDTH(W)) ifc ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs; the model decides acceptance purely from timing rules
    task automatic drive_cycle(input logic st, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic bin);
        exp_t       e;
        logic [W:0] full;
        @(negedge clk);
        ifc.start = st;
        ifc.A     = a;
        ifc.B     = b;
        ifc.Bin   = bin;
        if (st && rst_n && (cyc + 1) >= next_free) begin
            full        = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
            e.d         = full[W-1:0];
            e.bout      = full[W];
            e.done_edge = cyc + 1 + W;
            q.push_back(e);
            last_acc  = cyc + 1;
            next_free = cyc + 1 + W + 2;
        end
    endtask

    task automatic drive_rand(input logic st);
        drive_cycle(st, W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)),
                    1'($urandom_range(0, 1)));
    endtask

    // One accepted operation followed by stray start pulses while busy
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        drive_cycle(1'b1, a, b, bin);
        for (int i = 0; i < int'(W) + 2; i++) drive_rand(i == 1 || i == 3);
    endtask

    // Monitor: busy against model, done pops scoreboard, D/Bout hold otherwise
    always @(negedge clk) begin
        exp_t e;
        logic exp_busy;
        if (rst_n) begin
            exp_busy = (last_acc >= 0) && (cyc >= last_acc) && (cyc <= last_acc + int'(W));
            check("busy", 32'(ifc.busy), 32'(exp_busy));
            if (ifc.done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'(ifc.done), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("done_cycle", 32'(cyc), 32'(e.done_edge));
                    check("D", 32'(ifc.D), 32'(e.d));
                    check("Bout", 32'(ifc.Bout), 32'(e.bout));
                    last_d    = e.d;
                    last_bout = e.bout;
                end
            end else begin
                check("D_hold", 32'(ifc.D), 32'(last_d));
                check("Bout_hold", 32'(ifc.Bout), 32'(last_bout));
                if (q.size() > 0 && q[0].done_edge < cyc) begin
                    check("done_missing", 32'(ifc.done), 32'd1);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        ifc.start = 1'b0;
        ifc.A     = '0;
        ifc.B     = '0;
        ifc.Bin   = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(ifc.busy), 32'd0);
        check("rst_done", 32'(ifc.done), 32'd0);
        check("rst_D", 32'(ifc.D), 32'd0);
        check("rst_Bout", 32'(ifc.Bout), 32'd0);
        rst_n = 1'b1;

        run_op(4'b0000, 4'b0000, 1'b0);
        run_op(4'b1010, 4'b0011, 1'b0);
        run_op(4'b0000, 4'b1111, 1'b0);
        run_op(4'b1111, 4'b1111, 1'b1);
        run_op(4'b0101, 4'b0100, 1'b1);

        // start held high with operands changing every cycle
        for (int i = 0; i < 60; i++) drive_rand(1'b1);
        for (int i = 0; i < 300; i++) drive_rand($urandom_range(0, 3) == 0);
        for (int i = 0; i < int'(W) + 3; i++) drive_rand(1'b0);

        // Asynchronous reset two cycles into RUN
        drive_cycle(1'b1, 4'b1001, 4'b0110, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        rst_n     = 1'b0;
        ifc.start = 1'b0;
        #1;
        check("arst_busy", 32'(ifc.busy), 32'd0);
        check("arst_done", 32'(ifc.done), 32'd0);
        check("arst_D", 32'(ifc.D), 32'd0);
        check("arst_Bout", 32'(ifc.Bout), 32'd0);
        q.delete();
        last_acc  = -1000;
        last_d    = '0;
        last_bout = 1'b0;
        next_free = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < int'(W) + 3; i++) drive_rand(1'b0);

        run_op(4'b1001, 4'b0110, 1'b1);
        for (int i = 0; i < 100; i++) drive_rand($urandom_range(0, 1) == 1);
        for (int i = 0; i < int'(W) + 3; i++) drive_rand(1'b0);

        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
